pic_cmd_sequencer: RTL and testbench

Clocked, parametrised successor to the combinational bus control decoder of the 8259A-style interrupt controller.
- Synchronises the CPU bus strobes into the `clk` domain and captures written bytes.
- Runs the ICW1→ICW2→[ICW3]→[ICW4] initialisation state machine, then classifies later writes as OCW1/OCW2/OCW3.
- Issues one-cycle command pulses with held command registers to the interrupt-mask, priority-resolver and cascade blocks, and generates a registered read strobe.

---
 rtl/pic_cmd_sequencer_pkg.sv | 32 +++
 rtl/pic_cmd_sequencer_if.sv | 12 +
 rtl/pic_strobe_sync.sv | 35 +++
 rtl/pic_cmd_sequencer.sv | 151 +++++++++++++++
 tb/tb_pic_cmd_sequencer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/pic_cmd_sequencer_pkg.sv
// Shared types and constants for the 8259A-style command sequencer.
// Covers the init state enum, control-word bit positions and command slot indices.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } pic_state_e;

  localparam int ICW1_IC4   = 0;
  localparam int ICW1_SNGL  = 1;
  localparam int ICW1_ID    = 4;
  localparam int OCW_SEL_LO = 3;

  // Slot order of the pulse vector and command register file.
  localparam int CMD_ICW1 = 0;
  localparam int CMD_ICW2 = 1;
  localparam int CMD_ICW3 = 2;
  localparam int CMD_ICW4 = 3;
  localparam int CMD_OCW1 = 4;
  localparam int CMD_OCW2 = 5;
  localparam int CMD_OCW3 = 6;
  localparam int NUM_CMDS = 7;

  function automatic logic is_icw1(input logic a0, input logic [4:0] d);
    return ~a0 & d[ICW1_ID];
  endfunction

endpackage

// File: rtl/pic_cmd_sequencer_if.sv
// CPU-side bus of the command sequencer.
// Strobes are active low and asynchronous to the sequencer clock.
interface pic_cmd_sequencer_if #(parameter int DATA_WIDTH = 8);
  logic                  CS_bar;
  logic                  RD_bar;
  logic                  WR_bar;
  logic                  A0;
  logic [DATA_WIDTH-1:0] data_bus_in;

  modport master (output CS_bar, RD_bar, WR_bar, A0, data_bus_in);
  modport slave  (input  CS_bar, RD_bar, WR_bar, A0, data_bus_in);
endinterface

// File: rtl/pic_strobe_sync.sv
// Multi-flop synchroniser for an active-high strobe level, with one edge detector.
// RISE selects whether edge_o flags the rising or the falling synchronised edge.
module pic_strobe_sync #(
  parameter int SYNC_STAGES = 2,
  parameter bit RISE        = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic act_in,
  output logic edge_o,
  output logic busy_o
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], act_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign edge_o = RISE ? (sync_q[SYNC_STAGES-1] & ~prev_q)
                       : (~sync_q[SYNC_STAGES-1] & prev_q);
  // Busy spans the whole synchroniser so overlapping accesses are seen early.
  assign busy_o = |{sync_q, prev_q};
endmodule

// File: rtl/pic_cmd_sequencer.sv
// Clocked bus control decoder: synchronises CPU strobes, sequences ICW1..ICW4,
// classifies OCW1..OCW3 and issues one-cycle command pulses with held registers.
module pic_cmd_sequencer
  import pic_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CASCADE_EN  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  pic_cmd_sequencer_if.slave    bus,
  output logic                  icw1_pulse, icw2_pulse, icw3_pulse, icw4_pulse,
  output logic                  ocw1_pulse, ocw2_pulse, ocw3_pulse,
  output logic [DATA_WIDTH-1:0] icw1_reg, icw2_reg, icw3_reg, icw4_reg,
  output logic [DATA_WIDTH-1:0] ocw1_reg, ocw2_reg, ocw3_reg,
  output logic                  init_done,
  output logic                  read_strobe,
  output logic                  read_a0,
  output logic                  seq_error
);
  logic wr_raw, rd_raw, wr_fall, wr_busy, rd_rise, unused_rd_busy;

  assign wr_raw = ~bus.CS_bar & ~bus.WR_bar;
  assign rd_raw = ~bus.CS_bar & ~bus.RD_bar;

  pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE(1'b0)) u_wr_sync (
    .clk(clk), .rst(reset), .act_in(wr_raw), .edge_o(wr_fall), .busy_o(wr_busy)
  );
  pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES), .RISE(1'b1)) u_rd_sync (
    .clk(clk), .rst(reset), .act_in(rd_raw), .edge_o(rd_rise), .busy_o(unused_rd_busy)
  );

  pic_state_e            state_q, state_d;
  logic                  cap_a0_q, cap_a0_d;
  logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;
  logic [NUM_CMDS-1:0]   pulse_q, pulse_d;
  logic [DATA_WIDTH-1:0] cmd_reg_q [NUM_CMDS];
  logic [DATA_WIDTH-1:0] cmd_reg_d [NUM_CMDS];
  logic                  init_done_q, init_done_d;
  logic                  seq_error_q, seq_error_d;
  logic                  read_strobe_q, read_strobe_d;
  logic                  read_a0_q, read_a0_d;
  logic                  sngl, ic4;

  always_comb begin
    state_d       = state_q;
    cap_a0_d      = cap_a0_q;
    cap_data_d    = cap_data_q;
    pulse_d       = '0;
    cmd_reg_d     = cmd_reg_q;
    seq_error_d   = seq_error_q;
    init_done_d   = (state_q == READY);
    read_strobe_d = rd_rise & ~wr_busy;
    read_a0_d     = read_strobe_d ? bus.A0 : read_a0_q;
    sngl          = (CASCADE_EN == 0) || cmd_reg_q[CMD_ICW1][ICW1_SNGL];
    ic4           = cmd_reg_q[CMD_ICW1][ICW1_IC4];

    if (wr_raw) begin
      cap_a0_d   = bus.A0;
      cap_data_d = bus.data_bus_in;
    end

    if (wr_fall) begin
      if (is_icw1(cap_a0_q, cap_data_q[4:0])) begin
        pulse_d[CMD_ICW1]   = 1'b1;
        cmd_reg_d[CMD_ICW1] = cap_data_q;
        cmd_reg_d[CMD_OCW1] = '0;
        state_d             = WAIT_ICW2;
      end else begin
        unique case (state_q)
          IDLE: seq_error_d = 1'b1;
          WAIT_ICW2:
            if (cap_a0_q) begin
              pulse_d[CMD_ICW2]   = 1'b1;
              cmd_reg_d[CMD_ICW2] = cap_data_q;
              state_d = !sngl ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
            end else seq_error_d = 1'b1;
          WAIT_ICW3:
            if (cap_a0_q) begin
              pulse_d[CMD_ICW3]   = 1'b1;
              cmd_reg_d[CMD_ICW3] = cap_data_q;
              state_d = ic4 ? WAIT_ICW4 : READY;
            end else seq_error_d = 1'b1;
          WAIT_ICW4:
            if (cap_a0_q) begin
              pulse_d[CMD_ICW4]   = 1'b1;
              cmd_reg_d[CMD_ICW4] = cap_data_q;
              state_d = READY;
            end else seq_error_d = 1'b1;
          READY:
            // D4 is known 0 here, so D3 alone separates OCW2 from OCW3.
            if (cap_a0_q) begin
              pulse_d[CMD_OCW1]   = 1'b1;
              cmd_reg_d[CMD_OCW1] = cap_data_q;
            end else if (!cap_data_q[OCW_SEL_LO]) begin
              pulse_d[CMD_OCW2]   = 1'b1;
              cmd_reg_d[CMD_OCW2] = cap_data_q;
            end else begin
              pulse_d[CMD_OCW3]   = 1'b1;
              cmd_reg_d[CMD_OCW3] = cap_data_q;
            end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cap_a0_q      <= 1'b0;
      cap_data_q    <= '0;
      pulse_q       <= '0;
      for (int i = 0; i < NUM_CMDS; i++) cmd_reg_q[i] <= '0;
      init_done_q   <= 1'b0;
      seq_error_q   <= 1'b0;
      read_strobe_q <= 1'b0;
      read_a0_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cap_a0_q      <= cap_a0_d;
      cap_data_q    <= cap_data_d;
      pulse_q       <= pulse_d;
      cmd_reg_q     <= cmd_reg_d;
      init_done_q   <= init_done_d;
      seq_error_q   <= seq_error_d;
      read_strobe_q <= read_strobe_d;
      read_a0_q     <= read_a0_d;
    end
  end

  assign icw1_pulse  = pulse_q[CMD_ICW1];
  assign icw2_pulse  = pulse_q[CMD_ICW2];
  assign icw3_pulse  = pulse_q[CMD_ICW3];
  assign icw4_pulse  = pulse_q[CMD_ICW4];
  assign ocw1_pulse  = pulse_q[CMD_OCW1];
  assign ocw2_pulse  = pulse_q[CMD_OCW2];
  assign ocw3_pulse  = pulse_q[CMD_OCW3];
  assign icw1_reg    = cmd_reg_q[CMD_ICW1];
  assign icw2_reg    = cmd_reg_q[CMD_ICW2];
  assign icw3_reg    = cmd_reg_q[CMD_ICW3];
  assign icw4_reg    = cmd_reg_q[CMD_ICW4];
  assign ocw1_reg    = cmd_reg_q[CMD_OCW1];
  assign ocw2_reg    = cmd_reg_q[CMD_OCW2];
  assign ocw3_reg    = cmd_reg_q[CMD_OCW3];
  assign init_done   = init_done_q;
  assign seq_error   = seq_error_q;
  assign read_strobe = read_strobe_q;
  assign read_a0     = read_a0_q;
endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Directed-vector bench: one cascade-enabled and one cascade-disabled sequencer
// share a single CPU bus and are compared against hand-computed results.
module tb_pic_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pic_cmd_sequencer_if #(.DATA_WIDTH(8)) bus ();

  wire  [6:0] a_p, b_p;
  logic [7:0] a_r [7];
  logic [7:0] b_r [7];
  logic a_init, a_err, a_rs, a_ra, b_init, b_err, b_rs, b_ra;

  pic_cmd_sequencer #(.DATA_WIDTH(8), .SYNC_STAGES(2), .CASCADE_EN(1)) dut_a (
    .clk(clk), .reset(rst), .bus(bus),
    .icw1_pulse(a_p[0]), .icw2_pulse(a_p[1]), .icw3_pulse(a_p[2]), .icw4_pulse(a_p[3]),
    .ocw1_pulse(a_p[4]), .ocw2_pulse(a_p[5]), .ocw3_pulse(a_p[6]),
    .icw1_reg(a_r[0]), .icw2_reg(a_r[1]), .icw3_reg(a_r[2]), .icw4_reg(a_r[3]),
    .ocw1_reg(a_r[4]), .ocw2_reg(a_r[5]), .ocw3_reg(a_r[6]),
    .init_done(a_init), .read_strobe(a_rs), .read_a0(a_ra), .seq_error(a_err)
  );

  pic_cmd_sequencer #(.DATA_WIDTH(8), .SYNC_STAGES(2), .CASCADE_EN(0)) dut_b (
    .clk(clk), .reset(rst), .bus(bus),
    .icw1_pulse(b_p[0]), .icw2_pulse(b_p[1]), .icw3_pulse(b_p[2]), .icw4_pulse(b_p[3]),
    .ocw1_pulse(b_p[4]), .ocw2_pulse(b_p[5]), .ocw3_pulse(b_p[6]),
    .icw1_reg(b_r[0]), .icw2_reg(b_r[1]), .icw3_reg(b_r[2]), .icw4_reg(b_r[3]),
    .ocw1_reg(b_r[4]), .ocw2_reg(b_r[5]), .ocw3_reg(b_r[6]),
    .init_done(b_init), .read_strobe(b_rs), .read_a0(b_ra), .seq_error(b_err)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] seen_a, seen_b;
  int         npulse_a, lat, nrs;
  logic       init_p, init_n, grab;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_acc();
    seen_a = '0; seen_b = '0; npulse_a = 0; lat = -1; nrs = 0;
    init_p = 1'b0; init_n = 1'b0; grab = 1'b0;
  endtask

  task automatic sample(input int j);
    if (grab) begin
      init_n = a_init;
      grab   = 1'b0;
    end
    if (|a_p) begin
      npulse_a++;
      if (lat < 0) lat = j;
      init_p = a_init;
      grab   = 1'b1;
    end
    seen_a |= a_p;
    seen_b |= b_p;
    if (a_rs) nrs++;
  endtask

  // One bus access; latency j counts posedges after the strobes are released.
  task automatic bus_cycle(input logic a0, input logic [7:0] d, input logic wr,
                           input logic rd, input int hold);
    clear_acc();
    @(negedge clk);
    bus.A0 = a0; bus.data_bus_in = d;
    bus.CS_bar = 1'b0; bus.WR_bar = ~wr; bus.RD_bar = ~rd;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1; sample(100);
    end
    @(negedge clk);
    bus.CS_bar = 1'b1; bus.WR_bar = 1'b1; bus.RD_bar = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); #1; sample(j);
    end
  endtask

  task automatic wr(input logic a0, input logic [7:0] d);
    bus_cycle(a0, d, 1'b1, 1'b0, 3);
  endtask

  initial begin
    bus.CS_bar = 1'b1; bus.RD_bar = 1'b1; bus.WR_bar = 1'b1;
    bus.A0 = 1'b0; bus.data_bus_in = 8'h00;
    clear_acc();
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_pulses", {25'd0, a_p}, 32'h0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_init_done", {31'd0, a_init}, 32'h0);
    check_vec("rst_seq_error", {31'd0, a_err}, 32'h0);
    check_vec("rst_icw1_reg", {24'd0, a_r[0]}, 32'h0);
    check_vec("rst_read_a0", {31'd0, a_ra}, 32'h0);

    // OCW-form write before any ICW1
    wr(1'b0, 8'h20);
    check_vec("early_ocw_no_pulse", {25'd0, seen_a}, 32'h0);
    check_vec("early_ocw_seq_error", {31'd0, a_err}, 32'h1);

    // Single mode with ICW4
    wr(1'b0, 8'h13);
    check_vec("icw1_pulse", {25'd0, seen_a}, 32'h01);
    check_vec("icw1_latency", lat, 32'd3);
    check_vec("icw1_reg", {24'd0, a_r[0]}, 32'h13);
    wr(1'b1, 8'h20);
    check_vec("icw2_pulse", {25'd0, seen_a}, 32'h02);
    check_vec("icw2_reg", {24'd0, a_r[1]}, 32'h20);
    wr(1'b1, 8'h01);
    check_vec("icw4_pulse_no_icw3", {25'd0, seen_a}, 32'h08);
    check_vec("init_at_icw4_pulse", {31'd0, init_p}, 32'h0);
    check_vec("init_after_icw4", {31'd0, init_n}, 32'h1);
    check_vec("icw4_reg", {24'd0, a_r[3]}, 32'h01);
    check_vec("b_single_icw4", {25'd0, seen_b}, 32'h08);
    check_vec("seq_error_sticky", {31'd0, a_err}, 32'h1);

    // Operational words in READY
    wr(1'b1, 8'hFE);
    check_vec("ocw1_pulse", {25'd0, seen_a}, 32'h10);
    check_vec("ocw1_latency", lat, 32'd3);
    check_vec("ocw1_reg", {24'd0, a_r[4]}, 32'hFE);
    wr(1'b0, 8'h20);
    check_vec("ocw2_pulse", {25'd0, seen_a}, 32'h20);
    check_vec("ocw2_latency", lat, 32'd3);
    check_vec("ocw2_reg", {24'd0, a_r[5]}, 32'h20);
    wr(1'b0, 8'h0B);
    check_vec("ocw3_pulse", {25'd0, seen_a}, 32'h40);
    check_vec("ocw3_count", npulse_a, 32'd1);
    check_vec("ocw3_latency", lat, 32'd3);
    check_vec("ocw3_reg", {24'd0, a_r[6]}, 32'h0B);

    // Plain read, RD low for 4 clocks
    bus_cycle(1'b1, 8'h00, 1'b0, 1'b1, 4);
    check_vec("read_strobe_count", nrs, 32'd1);
    check_vec("read_a0", {31'd0, a_ra}, 32'h1);
    check_vec("read_no_pulse", {25'd0, seen_a}, 32'h0);
    check_vec("read_keeps_ready", {31'd0, a_init}, 32'h1);

    // Overlapping read and write: write wins
    bus_cycle(1'b1, 8'h55, 1'b1, 1'b1, 3);
    check_vec("overlap_no_read", nrs, 32'd0);
    check_vec("overlap_write_pulse", {25'd0, seen_a}, 32'h10);
    check_vec("overlap_ocw1_reg", {24'd0, a_r[4]}, 32'h55);

    // ICW1 while READY restarts the sequence
    wr(1'b0, 8'h13);
    check_vec("reinit_icw1_pulse", {25'd0, seen_a}, 32'h01);
    check_vec("reinit_init_drop", {31'd0, a_init}, 32'h0);
    check_vec("reinit_ocw1_clear", {24'd0, a_r[4]}, 32'h0);
    check_vec("reinit_seq_error", {31'd0, a_err}, 32'h1);

    // Cascade sequence; dut_b ignores SNGL and skips ICW3
    wr(1'b0, 8'h11);
    wr(1'b1, 8'h08);
    check_vec("casc_icw2_a", {25'd0, seen_a}, 32'h02);
    check_vec("casc_icw2_b", {25'd0, seen_b}, 32'h02);
    wr(1'b1, 8'h04);
    check_vec("casc_icw3_a", {25'd0, seen_a}, 32'h04);
    check_vec("casc_icw4_b", {25'd0, seen_b}, 32'h08);
    wr(1'b1, 8'h01);
    check_vec("casc_icw4_a", {25'd0, seen_a}, 32'h08);
    check_vec("casc_ocw1_b", {25'd0, seen_b}, 32'h10);
    check_vec("casc_icw3_reg_a", {24'd0, a_r[2]}, 32'h04);
    check_vec("casc_icw4_reg_a", {24'd0, a_r[3]}, 32'h01);
    check_vec("casc_init_a", {31'd0, a_init}, 32'h1);
    check_vec("nocasc_icw3_reg_b", {24'd0, b_r[2]}, 32'h00);
    check_vec("nocasc_icw4_reg_b", {24'd0, b_r[3]}, 32'h04);
    check_vec("nocasc_ocw1_reg_b", {24'd0, b_r[4]}, 32'h01);
    check_vec("nocasc_init_b", {31'd0, b_init}, 32'h1);

    // Reset asserted while a write is still in the synchroniser
    @(negedge clk);
    bus.A0 = 1'b0; bus.data_bus_in = 8'h13; bus.CS_bar = 1'b0; bus.WR_bar = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.CS_bar = 1'b1; bus.WR_bar = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_vec("midrst_init_done", {31'd0, a_init}, 32'h0);
    check_vec("midrst_icw1_reg", {24'd0, a_r[0]}, 32'h0);
    check_vec("midrst_ocw3_reg", {24'd0, a_r[6]}, 32'h0);
    check_vec("midrst_seq_error", {31'd0, a_err}, 32'h0);
    check_vec("midrst_pulses", {25'd0, a_p}, 32'h0);
    @(negedge clk); rst = 1'b0;
    clear_acc();
    for (int j = 1; j <= 8; j++) begin
      @(posedge clk); #1; sample(j);
    end
    check_vec("midrst_no_late_pulse", {25'd0, seen_a}, 32'h0);
    wr(1'b0, 8'h20);
    check_vec("midrst_idle_no_pulse", {25'd0, seen_a}, 32'h0);
    check_vec("midrst_idle_seq_error", {31'd0, a_err}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
